ni_out_buffer_mvc: RTL and testbench

Parametrised successor of the NI output buffer for the NI target/initiator response path. It holds flits in NUM_VC independent virtual-channel FIFOs and tracks downstream buffer space with per-VC credit counters. A wormhole-locking round-robin arbiter drives one flit per cycle onto the switch link. It sits between the NI packetiser and the switch input port, on noc_clk.

---
 rtl/noc_vc_pkg.sv | 17 +
 rtl/ni_out_buffer_mvc_if.sv | 31 +++
 rtl/ni_vc_fifo.sv | 52 +++++
 rtl/ni_out_buffer_mvc.sv | 135 +++++++++++++
 tb/tb_ni_out_buffer_mvc.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_vc_pkg.sv
// Shared definitions for the virtual-channel NI output path.
// Defaults, storage record sizing and error-flag bit positions.
package noc_vc_pkg;

    localparam int NUM_VC_DEF  = 2;
    localparam int CREDITS_DEF = 6;

    localparam int ERR_OVF = 0;
    localparam int ERR_CRD = 1;
    localparam int ERR_W   = 2;

    // FIFO record holds the flit with its tail marker on top
    function automatic int rec_width(input int flit_width);
        return flit_width + 1;
    endfunction

endpackage

// File: rtl/ni_out_buffer_mvc_if.sv
// Packetiser-side write port and switch-side link of the NI buffer.
// master = packetiser/switch environment, slave = the buffer.
interface ni_out_buffer_mvc_if
    import noc_vc_pkg::*;
#(
    parameter int FLIT_WIDTH = 80,
    parameter int NUM_VC     = NUM_VC_DEF,
    parameter int LOG_NUM_VC = 1
);
    logic [FLIT_WIDTH-1:0] data_in;
    logic                  write;
    logic [LOG_NUM_VC-1:0] vc_in;
    logic                  tail_in;
    logic [NUM_VC-1:0]     full;

    logic [FLIT_WIDTH-1:0] FLIT_out;
    logic                  VALID_out;
    logic [LOG_NUM_VC-1:0] VC_out;
    logic [NUM_VC-1:0]     credit_in;

    modport master (
        output data_in, write, vc_in, tail_in, credit_in,
        input  full, FLIT_out, VALID_out, VC_out
    );

    modport slave (
        input  data_in, write, vc_in, tail_in, credit_in,
        output full, FLIT_out, VALID_out, VC_out
    );

endinterface

// File: rtl/ni_vc_fifo.sv
// Single virtual-channel FIFO with occupancy count.
// DEPTH need not be a power of two; pointers wrap explicitly.
module ni_vc_fifo #(
    parameter int WIDTH     = 81,
    parameter int DEPTH     = 6,
    parameter int LOG_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH-1:0] count;

    function automatic logic [LOG_DEPTH-1:0] nxt(
        input logic [LOG_DEPTH-1:0] p
    );
        return (p == LOG_DEPTH'(DEPTH - 1)) ? '0 : p + LOG_DEPTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                count <= count + LOG_DEPTH'(1);
            else if (pop && !push)
                count <= count - LOG_DEPTH'(1);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == LOG_DEPTH'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ni_out_buffer_mvc.sv
// NI output buffer: per-VC FIFOs, credit tracking and a
// wormhole-locking round-robin arbiter onto the switch link.
module ni_out_buffer_mvc
    import noc_vc_pkg::*;
#(
    parameter int FLIT_WIDTH  = 80,
    parameter int NUM_VC      = NUM_VC_DEF,
    parameter int LOG_NUM_VC  = 1,
    parameter int DEPTH       = 6,
    parameter int LOG_DEPTH   = 3,
    parameter int CREDITS     = CREDITS_DEF,
    parameter int LOG_CREDITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    ni_out_buffer_mvc_if.slave  bus,
    output logic                overflow_err,
    output logic                credit_err
);

    localparam int REC_W = rec_width(FLIT_WIDTH);

    logic [NUM_VC-1:0]     push;
    logic [NUM_VC-1:0]     pop;
    logic [NUM_VC-1:0]     empty;
    logic [NUM_VC-1:0]     fifo_full;
    logic [NUM_VC-1:0]     elig;
    logic [NUM_VC-1:0]     crd_over;
    logic [REC_W-1:0]      head [NUM_VC];
    logic [REC_W-1:0]      gnt_rec;
    logic                  vc_ok;
    logic                  wr_ok;
    logic                  gnt;
    logic [LOG_NUM_VC-1:0] gnt_vc;
    logic [LOG_NUM_VC-1:0] rr_q;
    logic [LOG_NUM_VC-1:0] lock_vc_q;
    logic                  lock_q;
    logic [FLIT_WIDTH-1:0] flit_q;
    logic                  valid_q;
    logic [LOG_NUM_VC-1:0] vc_q;
    logic [ERR_W-1:0]      err_q;

    assign vc_ok = int'(bus.vc_in) < NUM_VC;
    assign wr_ok = bus.write && vc_ok && !fifo_full[bus.vc_in];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [LOG_CREDITS-1:0] credit_q;

        assign push[v] = wr_ok && (bus.vc_in == LOG_NUM_VC'(v));
        assign pop[v]  = gnt && (gnt_vc == LOG_NUM_VC'(v));

        ni_vc_fifo #(
            .WIDTH     (REC_W),
            .DEPTH     (DEPTH),
            .LOG_DEPTH (LOG_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[v]),
            .pop   (pop[v]),
            .wdata ({bus.tail_in, bus.data_in}),
            .rdata (head[v]),
            .full  (fifo_full[v]),
            .empty (empty[v])
        );

        // A same-cycle grant and credit return cancel out
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                credit_q <= LOG_CREDITS'(CREDITS);
            else if (pop[v] && !bus.credit_in[v])
                credit_q <= credit_q - LOG_CREDITS'(1);
            else if (!pop[v] && bus.credit_in[v] && !crd_over[v])
                credit_q <= credit_q + LOG_CREDITS'(1);
        end

        assign crd_over[v] = !pop[v] && bus.credit_in[v] &&
                             (credit_q == LOG_CREDITS'(CREDITS));
        assign elig[v] = !empty[v] && (credit_q != '0);
    end

    assign bus.full = fifo_full;

    // Reverse scan so the VC nearest after rr_q wins
    always_comb begin
        int idx;
        idx    = 0;
        gnt    = 1'b0;
        gnt_vc = '0;
        if (lock_q) begin
            gnt    = elig[lock_vc_q];
            gnt_vc = lock_vc_q;
        end else begin
            for (int i = NUM_VC; i >= 1; i--) begin
                idx = (int'(rr_q) + i) % NUM_VC;
                if (elig[idx]) begin
                    gnt    = 1'b1;
                    gnt_vc = LOG_NUM_VC'(idx);
                end
            end
        end
    end

    assign gnt_rec = head[gnt_vc];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
            rr_q      <= LOG_NUM_VC'(NUM_VC - 1);
            flit_q    <= '0;
            valid_q   <= 1'b0;
            vc_q      <= '0;
            err_q     <= '0;
        end else begin
            valid_q <= gnt;
            if (gnt) begin
                flit_q    <= gnt_rec[FLIT_WIDTH-1:0];
                vc_q      <= gnt_vc;
                rr_q      <= gnt_vc;
                lock_q    <= !gnt_rec[FLIT_WIDTH];
                lock_vc_q <= gnt_vc;
            end
            if (bus.write && !wr_ok) err_q[ERR_OVF] <= 1'b1;
            if (|crd_over)           err_q[ERR_CRD] <= 1'b1;
        end
    end

    assign bus.FLIT_out  = flit_q;
    assign bus.VALID_out = valid_q;
    assign bus.VC_out    = vc_q;
    assign overflow_err  = err_q[ERR_OVF];
    assign credit_err    = err_q[ERR_CRD];

endmodule

// File: tb/tb_ni_out_buffer_mvc.sv
// Bench for ni_out_buffer_mvc: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ni_out_buffer_mvc;

    localparam int FW    = 80;
    localparam int NV    = 2;
    localparam int LNV   = 1;
    localparam int DEPTH = 6;
    localparam int CR    = 6;

    typedef logic [FW:0] rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ovf;
    logic cerr;

    always #5 clk = ~clk;

    ni_out_buffer_mvc_if #(
        .FLIT_WIDTH(FW), .NUM_VC(NV), .LOG_NUM_VC(LNV)
    ) bus ();

    ni_out_buffer_mvc #(
        .FLIT_WIDTH(FW), .NUM_VC(NV), .LOG_NUM_VC(LNV),
        .DEPTH(DEPTH), .LOG_DEPTH(3),
        .CREDITS(CR), .LOG_CREDITS(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .overflow_err (ovf),
        .credit_err   (cerr)
    );

    int total = 0;
    int bad   = 0;
    int sent [NV];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference model: queues per VC, credit counts, packet lock
    rec_t            q [NV][$];
    int              cred [NV];
    bit              lk;
    int              lkv;
    int              last;
    logic [FW-1:0]   m_flit;
    bit              m_valid;
    int              m_vc;
    bit              m_ovf;
    bit              m_cerr;

    always @(posedge clk or negedge rst) begin : model
        int   g;
        int   v;
        rec_t rec;
        bit   wok;
        if (!rst) begin
            for (int i = 0; i < NV; i++) begin
                q[i].delete();
                cred[i] = CR;
            end
            lk = 0; lkv = 0; last = NV - 1;
            m_flit = '0; m_valid = 0; m_vc = 0;
            m_ovf = 0; m_cerr = 0;
        end else begin
            g = -1;
            if (lk) begin
                if (q[lkv].size() > 0 && cred[lkv] > 0) g = lkv;
            end else begin
                for (int i = 1; i <= NV; i++) begin
                    v = (last + i) % NV;
                    if (g < 0 && q[v].size() > 0 && cred[v] > 0) g = v;
                end
            end
            wok = bus.write && (int'(bus.vc_in) < NV) &&
                  (q[bus.vc_in].size() < DEPTH);
            if (bus.write && !wok) m_ovf = 1;
            m_valid = (g >= 0);
            if (g >= 0) begin
                rec = q[g].pop_front();
                cred[g]--;
                m_flit = rec[FW-1:0];
                m_vc = g; last = g;
                lk = !rec[FW]; lkv = g;
            end
            if (wok) q[bus.vc_in].push_back({bus.tail_in, bus.data_in});
            for (int i = 0; i < NV; i++) begin
                if (bus.credit_in[i]) begin
                    if (cred[i] == CR) m_cerr = 1;
                    else cred[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [NV-1:0] m_full;
        for (int i = 0; i < NV; i++) m_full[i] = (q[i].size() == DEPTH);
        chk("cmp_valid", bus.VALID_out, m_valid);
        chk("cmp_flit", bus.FLIT_out, m_flit);
        chk("cmp_vc", bus.VC_out, m_vc);
        chk("cmp_full", bus.full, m_full);
        chk("cmp_ovf", ovf, m_ovf);
        chk("cmp_cerr", cerr, m_cerr);
        if (rst && bus.VALID_out) sent[bus.VC_out]++;
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write = 0; bus.tail_in = 0; bus.vc_in = '0;
        bus.data_in = '0; bus.credit_in = '0;
    endtask

    task automatic do_reset();
        rst = 0;
        idle();
        cyc(2);
        rst = 1;
        for (int i = 0; i < NV; i++) sent[i] = 0;
    endtask

    task automatic wr(input int vc, input logic [FW-1:0] d, input bit t);
        bus.write = 1; bus.vc_in = LNV'(vc);
        bus.data_in = d; bus.tail_in = t;
        cyc();
        bus.write = 0; bus.tail_in = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        idle();
        for (int i = 0; i < NV; i++) sent[i] = 0;
        cyc();
        do_reset();
        chk("rst_valid", bus.VALID_out, 0);
        chk("rst_flit", bus.FLIT_out, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_errs", {ovf, cerr}, 0);

        // 3-flit packet on VC0, then credit exhaustion at 3 left
        wr(0, 'hA0, 0);
        wr(0, 'hA1, 0);
        chk("t1_head", {bus.VALID_out, bus.VC_out, bus.FLIT_out}, {2'b10, 80'hA0});
        wr(0, 'hA2, 1);
        chk("t1_mid", {bus.VALID_out, bus.FLIT_out}, {1'b1, 80'hA1});
        cyc();
        chk("t1_tail", {bus.VALID_out, bus.FLIT_out}, {1'b1, 80'hA2});
        cyc();
        chk("t1_idle", bus.VALID_out, 0);
        sent[0] = 0;
        for (int k = 0; k < 4; k++) wr(0, FW'('hA10 + k), 1);
        cyc(5);
        chk("t1_credit_left", sent[0], 3);

        // Lock holds VC0 through an empty stall; VC1 waits
        do_reset();
        wr(0, 'hB0, 0);
        wr(1, 'hC0, 1);
        chk("t2_head", {bus.VALID_out, bus.FLIT_out}, {1'b1, 80'hB0});
        wr(0, 'hB1, 0);
        chk("t2_stall", bus.VALID_out, 0);
        wr(0, 'hB2, 1);
        chk("t2_b1", {bus.VALID_out, bus.VC_out, bus.FLIT_out}, {2'b10, 80'hB1});
        cyc();
        chk("t2_b2", {bus.VALID_out, bus.VC_out, bus.FLIT_out}, {2'b10, 80'hB2});
        cyc();
        chk("t2_c0", {bus.VALID_out, bus.VC_out, bus.FLIT_out}, {2'b11, 80'hC0});

        // Credit limit on VC1
        do_reset();
        for (int k = 0; k < 8; k++) wr(1, FW'('hD0 + k), 1);
        cyc(4);
        chk("t3_sent6", sent[1], 6);
        for (int k = 0; k < 2; k++) begin
            bus.credit_in = 2'b10;
            cyc();
            bus.credit_in = '0;
            chk("t3_wait", bus.VALID_out, 0);
            cyc();
            chk("t3_resume", {bus.VALID_out, bus.VC_out, bus.FLIT_out},
                {2'b11, FW'('hD6 + k)});
        end
        cyc();
        chk("t3_sent8", sent[1], 8);

        // Fill VC0 with no credit, overflow, refused write on pop
        do_reset();
        for (int k = 0; k < 6; k++) wr(0, FW'('hE0 + k), 1);
        cyc(3);
        for (int k = 0; k < 6; k++) wr(0, FW'('hF0 + k), 1);
        chk("t4_full", bus.full, 2'b01);
        chk("t4_no_ovf", ovf, 0);
        wr(0, 'hBAD, 1);
        chk("t4_ovf", {ovf, bus.full}, 3'b101);
        bus.credit_in = 2'b01;
        cyc();
        bus.credit_in = '0;
        wr(0, 'hBAD2, 1);
        chk("t4_pop_refuse", bus.full, 2'b00);
        chk("t4_pop_flit", {bus.VALID_out, bus.FLIT_out}, {1'b1, 80'hF0});

        // Credit return alongside a grant, then at the cap
        do_reset();
        wr(0, 'h50, 1);
        bus.credit_in = 2'b01;
        cyc();
        chk("t5_same_cycle", {bus.VALID_out, cerr}, 2'b10);
        cyc();
        bus.credit_in = '0;
        chk("t5_at_max", cerr, 1);

        // Asynchronous reset in the middle of a VC1 packet
        do_reset();
        for (int k = 0; k < 4; k++) wr(1, FW'('h60 + k), 0);
        chk("t6_pre", {bus.VALID_out, bus.VC_out}, 2'b11);
        #2 rst = 0;
        #1;
        chk("t6_async", {bus.VALID_out, bus.VC_out, bus.FLIT_out}, '0);
        chk("t6_full", bus.full, 0);
        cyc(2);
        rst = 1;
        wr(0, 'h70, 0);
        wr(0, 'h71, 1);
        chk("t6_new_head", {bus.VALID_out, bus.VC_out, bus.FLIT_out}, {2'b10, 80'h70});
        cyc();
        chk("t6_new_tail", {bus.VALID_out, bus.FLIT_out}, {1'b1, 80'h71});
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
